// File: rtl/adder_share_arb.sv
// Shares one WIDTH-bit adder among NREQ requesters via round-robin; result registered, 1-cycle latency.
// Backpressure: while a held result is not accepted, all req_ready stay low; ADDER_SHARE_ARB_OVF_EN adds rsp_ovf.
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [IDW:0]   cand;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           grant_ok;
    logic           xfer;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH:0]   add_res;

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_valid[cand[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    assign grant_ok = (state_q == IDLE) || rsp_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        xfer      = 1'b0;
        if (!rst && grant_ok && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            xfer               = 1'b1;
            state_d            = HOLD;
            ptr_d              = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == HOLD && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign op_a    = req_a[gnt_idx*WIDTH +: WIDTH];
    assign op_b    = req_b[gnt_idx*WIDTH +: WIDTH];
    assign op_cin  = req_cin[gnt_idx];
    assign add_res = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else if (xfer) begin
            rsp_id   <= gnt_idx;
            rsp_sum  <= add_res[WIDTH-1:0];
            rsp_cout <= add_res[WIDTH];
        end
    end

`ifdef ADDER_SHARE_ARB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (xfer) begin
            rsp_ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                       (add_res[WIDTH-1] != op_a[WIDTH-1]);
        end
    end
`endif

    assign rsp_valid = (state_q == HOLD);

endmodule
